// File: rtl/sync_fifo_pack.sv
// Width-upsizing synchronous FIFO: packs RATIO narrow writes into one wide entry, pops whole entries.
// Optional zero-fill flush of a partial entry is enabled by defining SYNC_FIFO_PACK_FLUSH_EN.
module sync_fifo_pack #(
    parameter int DEPTH   = 8,
    parameter int DWIDTH  = 4,
    parameter int WRWIDTH = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               wr_ea,
    input  logic [WRWIDTH-1:0] din,
    input  logic               rd_ea,
`ifdef SYNC_FIFO_PACK_FLUSH_EN
    input  logic               flush,
`endif
    output logic [DWIDTH-1:0]  dout,
    output logic               dout_valid,
    output logic               empty,
    output logic               full,
    output logic               partial
);

    localparam int RATIO      = DWIDTH / WRWIDTH;
    localparam int RATIOLOG   = $clog2(RATIO);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int PTR_W      = ADDR_WIDTH + RATIOLOG + 1;

    localparam logic [PTR_W-1:0]      WR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   RD_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [RATIOLOG-1:0]   LANE_ZERO = {RATIOLOG{1'b0}};
    localparam logic [RATIO-1:0]      LANE_ONE  = {{(RATIO-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0]      wrptr_q, wrptr_d;
    logic [ADDR_WIDTH:0]   rdptr_q, rdptr_d;
    logic [DWIDTH-1:0]     dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [DWIDTH-1:0]     mem_q [DEPTH];

    logic                  wr_acc_s, rd_acc_s, flush_acc_s;
    logic [RATIOLOG-1:0]   lane_s;
    logic [ADDR_WIDTH-1:0] waddr_s;
    logic [RATIO-1:0]      lane_oh_s;
    logic [RATIO-1:0]      lane_we_s;
    logic [DWIDTH-1:0]     wdata_s;

    // Occupancy flags decoded from the pointers
    always_comb begin
        empty    = (wrptr_q[PTR_W-1:RATIOLOG] == rdptr_q);
        full     = (wrptr_q[PTR_W-2:RATIOLOG] == rdptr_q[ADDR_WIDTH-1:0]) &&
                   (wrptr_q[PTR_W-1] != rdptr_q[ADDR_WIDTH]);
        partial  = (wrptr_q[RATIOLOG-1:0] != LANE_ZERO);
        dout       = dout_q;
        dout_valid = dout_valid_q;
    end

    // Accept decisions, lane write enables and next-state pointers
    always_comb begin
        lane_s      = wrptr_q[RATIOLOG-1:0];
        waddr_s     = wrptr_q[PTR_W-2:RATIOLOG];
        lane_oh_s   = LANE_ONE << lane_s;
        wr_acc_s    = wr_ea && !full;
        rd_acc_s    = rd_ea && !empty;
`ifdef SYNC_FIFO_PACK_FLUSH_EN
        flush_acc_s = flush && partial && !full;
`else
        flush_acc_s = 1'b0;
`endif
        lane_we_s   = {RATIO{1'b0}};
        wdata_s     = {DWIDTH{1'b0}};
        // Flush zero-fills every lane from the current one upward; a concurrent write still owns its lane
        for (int l = 0; l < RATIO; l++) begin
            if (wr_acc_s && lane_oh_s[l]) begin
                lane_we_s[l] = 1'b1;
                wdata_s[l*WRWIDTH +: WRWIDTH] = din;
            end else if (flush_acc_s && ((lane_oh_s - LANE_ONE) & (LANE_ONE << l)) == {RATIO{1'b0}}) begin
                lane_we_s[l] = 1'b1;
            end else begin
                lane_we_s[l] = 1'b0;
            end
        end

        if (flush_acc_s) begin
            wrptr_d = {wrptr_q[PTR_W-1:RATIOLOG] + RD_ONE, LANE_ZERO};
        end else if (wr_acc_s) begin
            wrptr_d = wrptr_q + WR_ONE;
        end else begin
            wrptr_d = wrptr_q;
        end

        if (rd_acc_s) begin
            rdptr_d      = rdptr_q + RD_ONE;
            dout_d       = mem_q[rdptr_q[ADDR_WIDTH-1:0]];
            dout_valid_d = 1'b1;
        end else begin
            rdptr_d      = rdptr_q;
            dout_d       = dout_q;
            dout_valid_d = 1'b0;
        end
    end

    // Pointer and read-data registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrptr_q      <= {PTR_W{1'b0}};
            rdptr_q      <= {(ADDR_WIDTH+1){1'b0}};
            dout_q       <= {DWIDTH{1'b0}};
            dout_valid_q <= 1'b0;
        end else begin
            wrptr_q      <= wrptr_d;
            rdptr_q      <= rdptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Storage array with per-lane write enables; contents are intentionally not reset
    always_ff @(posedge clk) begin
        for (int l = 0; l < RATIO; l++) begin
            if (lane_we_s[l]) begin
                mem_q[waddr_s][l*WRWIDTH +: WRWIDTH] <= wdata_s[l*WRWIDTH +: WRWIDTH];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_pack.sv
// Self-checking bench for sync_fifo_pack (DEPTH=8, DWIDTH=4, WRWIDTH=1): vector table plus scoreboard model.
module tb_sync_fifo_pack;

`ifdef SYNC_FIFO_PACK_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic       wr_ea;
    logic [0:0] din;
    logic       rd_ea;
    logic       tb_flush;
    logic [3:0] dout;
    logic       dout_valid;
    logic       empty;
    logic       full;
    logic       partial;

    int n_checks;
    int n_fail;

    logic [3:0] sb_q[$];
    logic [3:0] cur_m;
    int         lane_m;
    logic [3:0] exp_dout;
    logic       exp_valid;

    typedef struct {
        logic       wr;
        logic       d;
        logic       rd;
        logic       e;
        logic       f;
        logic       p;
        logic       v;
        logic [3:0] dq;
    } vec_t;

    vec_t vecs[11];

    sync_fifo_pack #(.DEPTH(8), .DWIDTH(4), .WRWIDTH(1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_ea      (wr_ea),
        .din        (din),
        .rd_ea      (rd_ea),
`ifdef SYNC_FIFO_PACK_FLUSH_EN
        .flush      (tb_flush),
`endif
        .dout       (dout),
        .dout_valid (dout_valid),
        .empty      (empty),
        .full       (full),
        .partial    (partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        cur_m     = 4'b0000;
        lane_m    = 0;
        exp_dout  = 4'b0000;
        exp_valid = 1'b0;
    endtask

    task automatic push_entry();
        sb_q.push_back(cur_m);
        cur_m  = 4'b0000;
        lane_m = 0;
    endtask

    // One clock: drive, update the scoreboard from pre-edge state, compare after the edge
    task automatic step(input logic w, input logic d, input logic r);
        logic pre_full, pre_empty, pre_partial, fl;
        wr_ea = w;
        din   = d;
        rd_ea = r;
        pre_full    = (sb_q.size() == 8);
        pre_empty   = (sb_q.size() == 0);
        pre_partial = (lane_m != 0);
        fl          = tb_flush && FLUSH_EN;
        @(posedge clk);
        #1;
        if (r && !pre_empty) begin
            exp_dout  = sb_q.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        if (w && !pre_full) begin
            cur_m[lane_m] = d;
            lane_m++;
            if (lane_m == 4) push_entry();
        end
        if (fl && pre_partial && !pre_full && lane_m != 0) push_entry();
        chk("sb_dout",       int'(dout),       int'(exp_dout));
        chk("sb_dout_valid", int'(dout_valid), int'(exp_valid));
        chk("sb_empty",      int'(empty),      int'(sb_q.size() == 0));
        chk("sb_full",       int'(full),       int'(sb_q.size() == 8));
        chk("sb_partial",    int'(partial),    int'(lane_m != 0));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        wr_ea    = 1'b0;
        din      = 1'b0;
        rd_ea    = 1'b0;
        tb_flush = 1'b0;
        model_reset();

        // write 1,0,1,1 -> 4'b1101; then read held across 3 writes, 4th write enables it -> 4'b0110
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1101};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1101};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1101};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1101};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1101};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty",      int'(empty),      1);
        chk("rst_full",       int'(full),       0);
        chk("rst_partial",    int'(partial),    0);
        chk("rst_dout",       int'(dout),       0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        rstn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].wr, vecs[i].d, vecs[i].rd);
            chk($sformatf("vec%0d_empty", i),   int'(empty),      int'(vecs[i].e));
            chk($sformatf("vec%0d_full", i),    int'(full),       int'(vecs[i].f));
            chk($sformatf("vec%0d_partial", i), int'(partial),    int'(vecs[i].p));
            chk($sformatf("vec%0d_valid", i),   int'(dout_valid), int'(vecs[i].v));
            chk($sformatf("vec%0d_dout", i),    int'(dout),       int'(vecs[i].dq));
        end

        // fill: 32 writes (pointers are mid-array, so this also wraps)
        for (int i = 0; i < 32; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        chk("fill_full", int'(full), 1);
        step(1'b1, 1'b1, 1'b0);
        chk("drop_partial", int'(partial), 0);
        // full with read and write together: read wins, write dropped
        step(1'b1, 1'b1, 1'b1);
        chk("rdwr_full_clear", int'(full), 0);
        chk("rdwr_no_partial", int'(partial), 0);
        step(1'b1, 1'b1, 1'b0);
        chk("retry_partial", int'(partial), 1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1);
        chk("drain_empty", int'(empty), 1);
        step(1'b0, 1'b0, 1'b1);
        chk("empty_read_dropped", int'(dout_valid), 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // asynchronous reset with 2 entries plus 2 lanes stored
        for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_empty",   int'(empty),      1);
        chk("mid_rst_partial", int'(partial),    0);
        chk("mid_rst_full",    int'(full),       0);
        chk("mid_rst_dout",    int'(dout),       0);
        chk("mid_rst_valid",   int'(dout_valid), 0);
        model_reset();
        @(posedge clk);
        #3;
        rstn = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        step(1'b0, 1'b0, 1'b1);

`ifdef SYNC_FIFO_PACK_FLUSH_EN
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        tb_flush = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        tb_flush = 1'b0;
        chk("flush_visible", int'(empty), 0);
        step(1'b0, 1'b0, 1'b1);
        chk("flush_dout", int'(dout), 4'b0011);
        // flush together with a write: din lands first, rest zeroed
        step(1'b1, 1'b1, 1'b0);
        tb_flush = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        // flush with no partial entry is a no-op
        step(1'b0, 1'b0, 1'b0);
        tb_flush = 1'b0;
        chk("flush_noop_empty", int'(empty), 0);
        step(1'b0, 1'b0, 1'b1);
        chk("flush_wr_dout", int'(dout), 4'b0011);
`endif

        wr_ea = 1'b0;
        rd_ea = 1'b0;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_pack.md
Name: sync_fifo_pack

Overview:
Synchronous width-upsizing FIFO: the write side accepts narrow WRWIDTH-bit words and packs RATIO of them into one DWIDTH-bit entry; the read side pops whole DWIDTH-bit entries. It is the packing counterpart of the team's wide-write/narrow-read FIFO. It sits between a narrow serial/byte producer and a wide consumer on the same clock. Storage is an internal inferred memory with per-lane write enables and a registered read.

Parameters:
DEPTH, 8, number of DWIDTH-bit entries; power of 2, >=2
DWIDTH, 4, read-side (packed) word width
WRWIDTH, 1, write-side (narrow) word width; DWIDTH/WRWIDTH = RATIO, a power of 2, >=2

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  reset; asynchronous assert, active-low
wr_ea  input  1  write request for din
din  input  WRWIDTH  narrow data written into the FIFO
rd_ea  input  1  read request for one packed entry
dout  output  DWIDTH  packed data read from the FIFO, registered
dout_valid  output  1  high for one cycle when dout was updated by an accepted read
empty  output  1  no complete packed entry available
full  output  1  no free lane in the storage; writes ignored
partial  output  1  current write entry holds 1..RATIO-1 lanes

Behaviour:
- Localparams: RATIOLOG = log2(RATIO), ADDR_WIDTH = log2(DEPTH).
- wrptr is ADDR_WIDTH+RATIOLOG+1 bits and counts narrow words. The low RATIOLOG bits give the lane, the next ADDR_WIDTH bits give the entry, and the MSB is the wrap bit.
- rdptr is ADDR_WIDTH+1 bits and counts entries.
- Reset (rstn low, asynchronous): wrptr=0, rdptr=0, dout=0, dout_valid=0. Resulting outputs: empty=1, full=0, partial=0. Memory contents are not reset. Reset mid-operation discards all stored and partial data.
- Write accepted iff wr_ea && !full. On acceptance:
  - din goes to entry wrptr[entry], bits [lane*WRWIDTH +: WRWIDTH];
  - wrptr increments by 1.
  - Lane 0 is the LSBs: the first narrow word written lands in dout[WRWIDTH-1:0].
- Read accepted iff rd_ea && !empty. On acceptance:
  - mem[rdptr[ADDR_WIDTH-1:0]] is registered into dout at the same edge;
  - rdptr increments;
  - dout_valid=1 for the next cycle.
  - Read latency is 1 cycle.
- A read that is not accepted leaves dout unchanged and sets dout_valid=0.
- empty = (wrptr[MSB:RATIOLOG] == rdptr), combinational. An entry becomes visible only on the cycle after its last lane (lane RATIO-1) is written. Partially filled entries are never readable.
- full = (wrptr[entry] == rdptr[ADDR_WIDTH-1:0]) && (wrptr[MSB] != rdptr[MSB]), combinational.
- partial = (wrptr[RATIOLOG-1:0] != 0).
- Simultaneous read and write: both accepted when their conditions hold, evaluated on pre-edge flags. A read does not unblock a write in the same cycle while full=1. A write completing an entry does not make that entry readable in the same cycle.
- Wrap-around: pointers roll over naturally. Wrap bits disambiguate full/empty.
- A write when full is dropped, with no pointer or memory change. A read when empty is dropped.
- Capacity: DEPTH*RATIO narrow words.

Optional Feature:
- Macro: SYNC_FIFO_PACK_FLUSH_EN.
- Defined: adds input port flush (1 bit). When flush=1, partial=1 and !full:
  - all lanes >= current lane of the current entry are written with zero in one cycle;
  - wrptr advances to the next entry boundary, so the entry becomes readable next cycle.
  - flush with partial=0 is a no-op.
  - flush and wr_ea together: the write lane takes din first, then the remaining lanes are zeroed and wrptr advances to the boundary.
- Not defined: no flush port; a partial entry stays invisible until completed by writes.

Test Plan:
- Defaults used throughout (DEPTH=8, DWIDTH=4, WRWIDTH=1).
- Reset -> empty=1, full=0, partial=0, dout=0, dout_valid=0.
- Write din 1,0,1,1 on consecutive cycles -> partial=1 after 1st–3rd, empty=0 one cycle after 4th; then rd_ea -> next cycle dout=4'b1101, dout_valid=1, empty=1.
- 32 consecutive writes -> full=1 after 32nd; 33rd write ignored; 8 reads return the 8 packed values in order, and the 8th read leaves empty=1.
- Full plus simultaneous rd_ea and wr_ea -> read accepted, write dropped; next cycle full=0, and a retried write is accepted.
- 3 writes, then rd_ea held -> no read accepted, dout unchanged; 4th write -> read accepted the following cycle.
- Reset asserted mid-stream (2 entries plus 2 lanes stored) -> immediate empty=1, partial=0.
- With SYNC_FIFO_PACK_FLUSH_EN: write 1,1 then flush -> one read gives dout=4'b0011.
